// File: rtl/clock_div_prog_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the smallest legal divide ratio, the default counter width and
// ratio, and the high-time calculation used to shape div_clock.
package clock_div_prog_pkg;

  // Smallest ratio that still gives a clock with both a high and a low phase.
  localparam int MIN_DIV = 2;

  // Counter / ratio width used when the instantiating code does not override it.
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Ratio in force straight out of reset.
  localparam int DEFAULT_DIV_RATIO = 17;

  // High time for a ratio n is ceil(n/2). It is computed as floor(n/2) plus
  // the low bit, so that a ratio at the top of the counter range cannot
  // overflow the way n+1 would.
  function automatic logic [31:0] high_time(input logic [31:0] ratio);
    return (ratio >> 1) + {31'b0, ratio[0]};
  endfunction

endpackage

// File: rtl/clock_div_prog_if.sv
// Control and status bundle of the programmable clock divider.
// The master side owns enable and the ratio load strobe. The slave side (the
// divider) returns the divided clock, the tick enable and the sticky error flag.
interface clock_div_prog_if
  import clock_div_prog_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

  logic                 enable;
  logic [CNT_WIDTH-1:0] div_n;
  logic                 div_load;
  logic                 div_clock;
  logic                 tick;
  logic                 div_err;

  modport master (
    output enable,
    output div_n,
    output div_load,
    input  div_clock,
    input  tick,
    input  div_err
  );

  modport slave (
    input  enable,
    input  div_n,
    input  div_load,
    output div_clock,
    output tick,
    output div_err
  );

endinterface

// File: rtl/clock_div_prog.sv
// Run-time programmable integer clock divider.
// The whole block runs on the single input clock. The divided clock is a
// registered output and is never used as a clock inside this block. A free
// running counter walks through 0 .. active_n-1. div_clock is high for the
// first ceil(active_n/2) counts of each period, and tick pulses for one cycle
// when the counter wraps to 0.
// A new ratio is held in a shadow register and is only switched in at the
// next wrap. This means a running period is never cut short.
module clock_div_prog
  import clock_div_prog_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO
)(
  input  logic              clock,
  input  logic              reset,
  clock_div_prog_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_RATIO = CNT_WIDTH'(MIN_DIV);
  localparam logic [CNT_WIDTH-1:0] RST_RATIO = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] RST_CNT   = CNT_WIDTH'(DEFAULT_DIV - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] active_n;
  logic [CNT_WIDTH-1:0] pending_n;
  logic                 pending_vld;
  logic                 div_clock_q;
  logic                 tick_q;
  logic                 div_err_q;

  logic                 at_wrap;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] ratio_next;
  logic                 high_next;
  logic                 load_ok;
  logic                 load_bad;

  // Decide where the counter goes next and which ratio governs that count.
  // The reset value cnt = DEFAULT_DIV-1 makes the first enabled edge a wrap,
  // so div_clock and tick both rise on that edge.
  always_comb begin
    at_wrap    = 1'b0;
    cnt_next   = cnt;
    ratio_next = active_n;
    high_next  = 1'b0;
    load_ok    = 1'b0;
    load_bad   = 1'b0;

    at_wrap    = (cnt == active_n - ONE);
    cnt_next   = at_wrap ? '0 : cnt + ONE;
    ratio_next = (at_wrap && pending_vld) ? pending_n : active_n;
    high_next  = (32'(cnt_next) < high_time(32'(ratio_next)));
    load_ok    = bus.div_load && (bus.div_n >= MIN_RATIO);
    load_bad   = bus.div_load && (bus.div_n <  MIN_RATIO);
  end

  // Counter, active ratio and registered outputs; frozen (tick held low) while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= RST_CNT;
      active_n    <= RST_RATIO;
      div_clock_q <= 1'b0;
      tick_q      <= 1'b0;
    end else if (bus.enable) begin
      cnt         <= cnt_next;
      active_n    <= ratio_next;
      div_clock_q <= high_next;
      tick_q      <= (cnt_next == '0);
    end else begin
      tick_q      <= 1'b0;
    end
  end

  // Shadow ratio register and sticky error flag.
  // A load on a wrap edge re-arms pending_vld, so the new ratio waits for the following wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_n   <= RST_RATIO;
      pending_vld <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      if (load_ok) begin
        pending_n   <= bus.div_n;
        pending_vld <= 1'b1;
      end else if (bus.enable && at_wrap) begin
        pending_vld <= 1'b0;
      end
      if (load_bad) begin
        div_err_q <= 1'b1;
      end
    end
  end

  assign bus.div_clock = div_clock_q;
  assign bus.tick      = tick_q;
  assign bus.div_err   = div_err_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Testbench for clock_div_prog.
// A reference model predicts div_clock, tick and div_err on every clock edge
// and pushes the prediction into a queue. A checker on the falling edge pops
// each prediction and compares it with the DUT outputs. Period and duty
// measurements are compared with a table of hand-computed constants. A second
// 4-bit instance covers the maximum ratio, 2^CNT_WIDTH-1.
module tb_clock_div_prog;

  localparam int W  = 16;
  localparam int SW = 4;

  typedef struct {
    bit dc;
    bit tick;
    bit err;
  } exp_t;

  typedef struct {
    int n;
    int period;
    int highs;
  } vec_t;

  logic clk;
  logic rst_n;

  clock_div_prog_if #(.CNT_WIDTH(W))  bus();
  clock_div_prog_if #(.CNT_WIDTH(SW)) sbus();

  clock_div_prog #(.CNT_WIDTH(W), .DEFAULT_DIV(17)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  clock_div_prog #(.CNT_WIDTH(SW), .DEFAULT_DIV(15)) dut_max (
    .clock (clk),
    .reset (rst_n),
    .bus   (sbus.slave)
  );

  exp_t sb[$];
  int   checks;
  int   errors;

  int   m_pos;
  int   m_ratio;
  int   m_pend;
  bit   m_pend_vld;
  bit   m_err;
  bit   m_dc;
  bit   m_tick;

  bit   s_dc;
  bit   s_tick;
  bit   s_err;
  bit   sm_dc;
  bit   sm_tick;

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard checker: compares each prediction with the DUT outputs
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output("sb_div_clock", int'(bus.div_clock), int'(e.dc));
      check_output("sb_tick", int'(bus.tick), int'(e.tick));
      check_output("sb_div_err", int'(bus.div_err), int'(e.err));
    end
  end

  // Reference behaviour for one rising edge with the given inputs
  task automatic model_edge(input bit en, input int dn, input bit dl);
    bit old_vld;
    int old_pend;
    exp_t e;
    old_vld  = m_pend_vld;
    old_pend = m_pend;
    if (en) begin
      if (m_pos + 1 == m_ratio) begin
        m_pos = 0;
        if (old_vld) begin
          m_ratio    = old_pend;
          m_pend_vld = 1'b0;
        end
      end else begin
        m_pos++;
      end
      m_dc   = (2 * m_pos < m_ratio);
      m_tick = (m_pos == 0);
    end else begin
      m_tick = 1'b0;
    end
    if (dl) begin
      if (dn >= 2) begin
        m_pend     = dn;
        m_pend_vld = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    e.dc   = m_dc;
    e.tick = m_tick;
    e.err  = m_err;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input bit en, input int dn, input bit dl);
    @(negedge clk);
    bus.enable   = en;
    bus.div_n    = W'(dn);
    bus.div_load = dl;
    @(posedge clk);
    model_edge(en, dn, dl);
    #1;
    s_dc    = bus.div_clock;
    s_tick  = bus.tick;
    s_err   = bus.div_err;
    sm_dc   = sbus.div_clock;
    sm_tick = sbus.tick;
  endtask

  task automatic do_reset();
    #2;
    rst_n        = 1'b0;
    bus.enable   = 1'b0;
    bus.div_load = 1'b0;
    #1;
    check_output("rst_div_clock", int'(bus.div_clock), 0);
    check_output("rst_tick", int'(bus.tick), 0);
    check_output("rst_div_err", int'(bus.div_err), 0);
    sb.delete();
    m_pos      = 16;
    m_ratio    = 17;
    m_pend     = 17;
    m_pend_vld = 1'b0;
    m_err      = 1'b0;
    m_dc       = 1'b0;
    m_tick     = 1'b0;
    s_dc       = 1'b0;
    s_tick     = 1'b0;
    s_err      = 1'b0;
    sm_dc      = 1'b0;
    sm_tick    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Measures one full period of the main divider, starting at the next tick
  // (or at the current tick if the last step produced one)
  task automatic measure(output int period, output int highs);
    int guard;
    guard  = 0;
    period = 0;
    highs  = 0;
    while (!s_tick && guard < 300) begin
      apply_stimulus(1'b1, 0, 1'b0);
      guard++;
    end
    if (!s_tick) begin
      check_output("tick_timeout", 0, 1);
      period = -1;
      return;
    end
    do begin
      period++;
      if (s_dc) highs++;
      apply_stimulus(1'b1, 0, 1'b0);
    end while (!s_tick && period < 300);
  endtask

  task automatic measure_small(output int period, output int highs);
    int guard;
    guard  = 0;
    period = 0;
    highs  = 0;
    while (!sm_tick && guard < 100) begin
      apply_stimulus(1'b1, 0, 1'b0);
      guard++;
    end
    if (!sm_tick) begin
      check_output("max_tick_timeout", 0, 1);
      period = -1;
      return;
    end
    do begin
      period++;
      if (sm_dc) highs++;
      apply_stimulus(1'b1, 0, 1'b0);
    end while (!sm_tick && period < 100);
  endtask

  initial begin
    vec_t vecs[5];
    int   per;
    int   hi;
    int   cnt;

    vecs[0] = '{n: 2,  period: 2,  highs: 1};
    vecs[1] = '{n: 3,  period: 3,  highs: 2};
    vecs[2] = '{n: 7,  period: 7,  highs: 4};
    vecs[3] = '{n: 17, period: 17, highs: 9};
    vecs[4] = '{n: 10, period: 10, highs: 5};

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b1;
    bus.enable    = 1'b0;
    bus.div_n     = '0;
    bus.div_load  = 1'b0;
    sbus.enable   = 1'b1;
    sbus.div_n    = '0;
    sbus.div_load = 1'b0;

    // Default ratio out of reset: first enabled edge ticks, then 9 high / 8 low
    do_reset();
    apply_stimulus(1'b1, 0, 1'b0);
    check_output("first_edge_tick", int'(s_tick), 1);
    check_output("first_edge_clock", int'(s_dc), 1);
    measure(per, hi);
    check_output("default_period", per, 17);
    check_output("default_high", hi, 9);

    // Load 4 mid-period: the running 17-cycle period completes first
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 0, 1'b0);
    apply_stimulus(1'b1, 4, 1'b1);
    cnt = 6;
    while (!s_tick && cnt < 100) begin
      apply_stimulus(1'b1, 0, 1'b0);
      cnt++;
    end
    check_output("old_period_completes", cnt, 17);
    measure(per, hi);
    check_output("n4_period", per, 4);
    check_output("n4_high", hi, 2);

    // Two loads before a wrap: the last one wins and 5 never appears
    apply_stimulus(1'b1, 5, 1'b1);
    apply_stimulus(1'b1, 6, 1'b1);
    measure(per, hi);
    check_output("last_load_period", per, 6);
    check_output("last_load_high", hi, 3);
    measure(per, hi);
    check_output("last_load_period2", per, 6);

    // Table of ratios, including the minimum ratio of 2
    foreach (vecs[i]) begin
      apply_stimulus(1'b1, vecs[i].n, 1'b1);
      measure(per, hi);
      check_output($sformatf("tbl_period_n%0d", vecs[i].n), per, vecs[i].period);
      check_output($sformatf("tbl_high_n%0d", vecs[i].n), hi, vecs[i].highs);
    end

    // Illegal loads of 1 and 0 set the sticky error and leave the ratio alone
    apply_stimulus(1'b1, 1, 1'b1);
    check_output("err_after_n1", int'(s_err), 1);
    apply_stimulus(1'b1, 0, 1'b1);
    measure(per, hi);
    check_output("ratio_kept_after_bad", per, 10);
    check_output("err_sticky", int'(s_err), 1);

    // Freeze for 10 cycles in the high phase, then resume at the same count
    apply_stimulus(1'b1, 0, 1'b0);
    apply_stimulus(1'b1, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 0, 1'b0);
      check_output("freeze_clock_high", int'(s_dc), 1);
      check_output("freeze_no_tick", int'(s_tick), 0);
    end
    cnt = 0;
    do begin
      apply_stimulus(1'b1, 0, 1'b0);
      cnt++;
    end while (!s_tick && cnt < 100);
    check_output("resume_remaining", cnt, 8);

    // Reset in the middle of a high phase while a load is pending
    apply_stimulus(1'b1, 4, 1'b1);
    apply_stimulus(1'b1, 0, 1'b0);
    check_output("pre_reset_high", int'(s_dc), 1);
    do_reset();
    measure(per, hi);
    check_output("post_reset_period", per, 17);
    check_output("post_reset_high", hi, 9);
    check_output("post_reset_err", int'(s_err), 0);

    // Maximum ratio on the 4-bit instance: 15 cycles, 8 high
    measure_small(per, hi);
    check_output("max_period", per, 15);
    check_output("max_high", hi, 8);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
